// File: rtl/sensor_init_sequencer.sv
// sensor_init_sequencer: walks a per-mode register table in ROM and
// issues {addr,data} writes over valid/ready. Macro: SENSOR_SEQ_DELAY_EN.
module sensor_init_sequencer #(
   parameter int REG_ADDR_W = 8,
   parameter int REG_DATA_W = 8,
   parameter int DEPTH = 64,
   parameter int NUM_MODES = 2,
   parameter int DELAY_TICKS_PER_MS = 25000,
   localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
   localparam int ROM_AW = (NUM_MODES * DEPTH > 1) ?
                           $clog2(NUM_MODES * DEPTH) : 1,
   localparam int VAL_W = REG_ADDR_W + REG_DATA_W,
   localparam int ENT_W = 2 + VAL_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [MODE_W-1:0]     mode,
   output logic [ROM_AW-1:0]     rom_addr,
   input  logic [ENT_W-1:0]      rom_data,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [REG_ADDR_W-1:0] cmd_addr,
   output logic [REG_DATA_W-1:0] cmd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_DELAY = 2'b01;
   localparam logic [1:0] OP_END   = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

`ifdef SENSOR_SEQ_DELAY_EN
   localparam longint MAX_TICKS =
      ((longint'(1) << VAL_W) - 1) * longint'(DELAY_TICKS_PER_MS);
   localparam int CNT_W = (MAX_TICKS > 1) ? $clog2(MAX_TICKS + 1) : 1;
`endif

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      ISSUE,
`ifdef SENSOR_SEQ_DELAY_EN
      DELAY,
`endif
      DONE
   } state_t;

   state_t                state_q, state_n;
   logic [IDX_W-1:0]      idx_q, idx_n;
   logic [ROM_AW-1:0]     base_q, base_n;
   logic [ROM_AW-1:0]     rom_addr_n;
   logic                  cmd_valid_n;
   logic [REG_ADDR_W-1:0] cmd_addr_n;
   logic [REG_DATA_W-1:0] cmd_data_n;
   logic                  busy_n, done_n, error_n;
   logic                  adv;
   logic [1:0]            op;

   assign op = rom_data[ENT_W-1:VAL_W];

`ifdef SENSOR_SEQ_DELAY_EN
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [VAL_W-1:0] val;
   assign val = rom_data[VAL_W-1:0];
`endif

   // Next-state and next-output logic; adv steps to the next table entry.
   always_comb begin
      state_n     = state_q;
      idx_n       = idx_q;
      base_n      = base_q;
      rom_addr_n  = rom_addr;
      cmd_valid_n = cmd_valid;
      cmd_addr_n  = cmd_addr;
      cmd_data_n  = cmd_data;
      busy_n      = busy;
      done_n      = done;
      error_n     = error;
      adv         = 1'b0;
`ifdef SENSOR_SEQ_DELAY_EN
      cnt_n       = cnt_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               idx_n   = '0;
               done_n  = 1'b0;
               error_n = 1'b0;
               if (int'(mode) >= NUM_MODES) begin
                  state_n = DONE;
                  done_n  = 1'b1;
                  error_n = 1'b1;
               end else begin
                  state_n    = FETCH;
                  busy_n     = 1'b1;
                  base_n     = ROM_AW'(int'(mode) * DEPTH);
                  rom_addr_n = base_n;
               end
            end
         end
         FETCH: state_n = DECODE;
         DECODE: begin
            unique case (op)
               OP_WRITE: begin
                  state_n     = ISSUE;
                  cmd_valid_n = 1'b1;
                  cmd_addr_n  = rom_data[VAL_W-1:REG_DATA_W];
                  cmd_data_n  = rom_data[REG_DATA_W-1:0];
               end
               OP_DELAY: begin
`ifdef SENSOR_SEQ_DELAY_EN
                  if (val == '0) begin
                     adv = 1'b1;
                  end else begin
                     cnt_n = CNT_W'(val) * CNT_W'(DELAY_TICKS_PER_MS)
                             - CNT_W'(1);
                     state_n = DELAY;
                  end
`else
                  adv = 1'b1;
`endif
               end
               OP_END: begin
                  state_n = DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
               end
               OP_RSVD: begin
                  state_n = DONE;
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  error_n = 1'b1;
               end
            endcase
         end
         ISSUE: begin
            if (cmd_ready) begin
               cmd_valid_n = 1'b0;
               adv         = 1'b1;
            end
         end
`ifdef SENSOR_SEQ_DELAY_EN
         DELAY: begin
            if (cnt_q == '0) adv = 1'b1;
            else cnt_n = cnt_q - CNT_W'(1);
         end
`endif
         default: state_n = IDLE;
      endcase
      if (adv) begin
         if (idx_q == IDX_W'(DEPTH - 1)) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            error_n = 1'b1;
         end else begin
            idx_n      = idx_q + IDX_W'(1);
            rom_addr_n = base_q + ROM_AW'(idx_n);
            state_n    = FETCH;
         end
      end
   end

   // State and registered outputs, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         base_q    <= '0;
         rom_addr  <= '0;
         cmd_valid <= 1'b0;
         cmd_addr  <= '0;
         cmd_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
`ifdef SENSOR_SEQ_DELAY_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_n;
         idx_q     <= idx_n;
         base_q    <= base_n;
         rom_addr  <= rom_addr_n;
         cmd_valid <= cmd_valid_n;
         cmd_addr  <= cmd_addr_n;
         cmd_data  <= cmd_data_n;
         busy      <= busy_n;
         done      <= done_n;
         error     <= error_n;
`ifdef SENSOR_SEQ_DELAY_EN
         cnt_q     <= cnt_n;
`endif
      end
   end

endmodule

// File: tb/tb_sensor_init_sequencer.sv
// tb_sensor_init_sequencer: directed and random tables checked against
// a per-entry cycle-cost model of the sequencer.
module tb_sensor_init_sequencer;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int DEPTH = 8;
   localparam int NM = 2;
   localparam int TPM = 10;
   localparam int RAW = 4;
   localparam int EW = 18;
`ifdef SENSOR_SEQ_DELAY_EN
   localparam bit DLY_EN = 1'b1;
`else
   localparam bit DLY_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      int         t;
   } cmd_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [0:0]    mode = 1'b0;
   logic [RAW-1:0] rom_addr;
   logic [EW-1:0] rom_data = '0;
   logic          cmd_valid;
   logic          cmd_ready = 1'b1;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic          busy, done, error;

   logic [EW-1:0] rom [NM*DEPTH];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;
   cmd_t hs_q[$];
   cmd_t exp_q[$];
   int   exp_t;
   logic exp_err;

   sensor_init_sequencer #(
      .REG_ADDR_W(AW),
      .REG_DATA_W(DW),
      .DEPTH(DEPTH),
      .NUM_MODES(NM),
      .DELAY_TICKS_PER_MS(TPM)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .mode(mode),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr),
      .cmd_data(cmd_data),
      .busy(busy),
      .done(done),
      .error(error)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // synchronous ROM: data valid one cycle after the address
   always @(posedge clk) rom_data <= rom[rom_addr];

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) cmd_ready = 1'b1;
      else if (rdy_mode == 1) cmd_ready = 1'($urandom % 2);
      else cmd_ready = 1'b0;
   end

   initial forever begin
      cmd_t c;
      @(negedge clk);
      if (rst_n && cmd_valid && cmd_ready) begin
         c.a = cmd_addr;
         c.d = cmd_data;
         c.t = cyc + 1;
         hs_q.push_back(c);
      end
   end

   function automatic logic [EW-1:0] wr(input logic [7:0] a,
                                        input logic [7:0] d);
      return {2'b00, a, d};
   endfunction

   function automatic logic [EW-1:0] dl(input int ms);
      return {2'b01, 16'(ms)};
   endfunction

   function automatic logic [EW-1:0] ende();
      return {2'b10, 16'h0};
   endfunction

   function automatic logic [EW-1:0] rsv();
      return {2'b11, 16'h0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cost per entry measured from its FETCH: WRITE 3, DELAY 2+D*TPM,
   // END/reserved decide after 2; a table without END errors after last.
   task automatic model(input int m);
      logic [EW-1:0] e;
      cmd_t c;
      int t;
      bit term;
      t = 0;
      term = 1'b0;
      exp_q.delete();
      exp_err = 1'b1;
      for (int i = 0; i < DEPTH && !term; i++) begin
         e = rom[m*DEPTH+i];
         case (e[17:16])
            2'b00: begin
               t += 3;
               c.a = e[15:8];
               c.d = e[7:0];
               c.t = t;
               exp_q.push_back(c);
            end
            2'b01: begin
               t += 2;
               if (DLY_EN) t += int'(e[15:0]) * TPM;
            end
            2'b10: begin
               t += 2;
               exp_err = 1'b0;
               term = 1'b1;
            end
            default: begin
               t += 2;
               term = 1'b1;
            end
         endcase
      end
      exp_t = t;
   endtask

   task automatic run(input int m, input int rm, input bit tm,
                      input int poke);
      int s;
      int n;
      model(m);
      hs_q.delete();
      @(negedge clk);
      rdy_mode = rm;
      mode = 1'(m);
      start = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 1);
      chk("rom_base", 64'(rom_addr), 64'(m * DEPTH));
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
         if (n == poke) begin
            mode = ~mode;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("timeout", 64'(n < 3000), 1);
      chk("error", 64'(error), 64'(exp_err));
      chk("busy_end", 64'(busy), 0);
      if (tm) chk("done_time", 64'(cyc - s), 64'(exp_t));
      chk("n_cmds", 64'(hs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++) begin
         chk("cmd_addr", 64'(hs_q[i].a), 64'(exp_q[i].a));
         chk("cmd_data", 64'(hs_q[i].d), 64'(exp_q[i].d));
         if (tm) chk("cmd_time", 64'(hs_q[i].t - s), 64'(exp_q[i].t));
      end
      rdy_mode = 0;
   endtask

   initial begin
      int n;
      int m;
      int len;
      int rm;

      for (int i = 0; i < NM*DEPTH; i++) rom[i] = ende();
      rom[0] = wr(8'h12, 8'h80);
      rom[1] = wr(8'h11, 8'h00);
      rom[2] = ende();

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs",
          64'({rom_addr, cmd_valid, cmd_addr, cmd_data, busy, done, error}),
          0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic two-write table, ready tied high
      run(0, 0, 1'b1, 0);
      chk("done_held", 64'(done), 1);

      // back-pressure: ready low while first command waits
      hs_q.delete();
      @(negedge clk);
      rdy_mode = 2;
      mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!cmd_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("stall_valid", 64'(cmd_valid), 1);
      for (int i = 0; i < 10; i++) begin
         chk("stall_hold", 64'({cmd_valid, cmd_addr, cmd_data}),
             64'({1'b1, 8'h12, 8'h80}));
         @(negedge clk);
      end
      rdy_mode = 0;
      n = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stall_done", 64'(done), 1);
      chk("stall_ncmd", 64'(hs_q.size()), 2);
      if (hs_q.size() > 0)
         chk("stall_first", 64'({hs_q[0].a, hs_q[0].d}), 64'(16'h1280));

      // delay entry between two writes, from DONE into mode 1
      rom[DEPTH+0] = wr(8'h20, 8'h01);
      rom[DEPTH+1] = dl(2);
      rom[DEPTH+2] = wr(8'h21, 8'h02);
      rom[DEPTH+3] = ende();
      run(1, 0, 1'b1, 0);

      // table overflow: DEPTH writes and no END
      for (int i = 0; i < DEPTH; i++)
         rom[DEPTH+i] = wr(8'(8'h50 + i), 8'(i * 3));
      run(1, 0, 1'b1, 0);

      // reserved opcode
      rom[DEPTH+0] = wr(8'h30, 8'h03);
      rom[DEPTH+1] = rsv();
      run(1, 0, 1'b1, 0);

      // start pulsed while busy is ignored
      run(0, 0, 1'b1, 2);

      // asynchronous reset while a command is pending
      rom[DEPTH+0] = wr(8'h40, 8'h04);
      rom[DEPTH+1] = wr(8'h41, 8'h05);
      rom[DEPTH+2] = ende();
      @(negedge clk);
      rdy_mode = 2;
      mode = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!cmd_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rst_pre_valid", 64'(cmd_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async",
          64'({rom_addr, cmd_valid, cmd_addr, cmd_data, busy, done, error}),
          0);
      @(negedge clk);
      rst_n = 1'b1;
      rdy_mode = 0;
      run(1, 0, 1'b1, 0);

      // random tables, random back-pressure
      for (int it = 0; it < 24; it++) begin
         m = int'($urandom % 2);
         len = int'($urandom_range(1, DEPTH));
         rm = int'($urandom % 2);
         for (int i = 0; i < DEPTH; i++) begin
            if (i < len)
               rom[m*DEPTH+i] = ($urandom % 4 == 0) ?
                  dl(int'($urandom % 3)) : wr(8'($urandom), 8'($urandom));
            else if (i == len)
               rom[m*DEPTH+i] = ($urandom % 4 == 0) ? rsv() : ende();
            else
               rom[m*DEPTH+i] = ende();
         end
         run(m, rm, rm == 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/sensor_init_sequencer.md
# sensor_init_sequencer

Parametrised camera-sensor initialisation sequencer: walks an external register-table ROM for a selected mode and issues {register address, value} write commands over a valid/ready handshake to the SCCB/I2C master. Sits between the configuration ROM and the serial-bus master in the camera capture path. It is the generalised successor of the fixed 16-bit command ROM, with:
- configurable address and data widths
- multiple mode tables
- timed delay entries
- an explicit end-of-table marker
- restartable operation

## Interface
Parameters:
- REG_ADDR_W, 8, sensor register address width
- REG_DATA_W, 8, sensor register value width
- DEPTH, 64, maximum entries per mode table
- NUM_MODES, 2, number of mode tables stored back-to-back in ROM
- DELAY_TICKS_PER_MS, 25000, clk cycles per millisecond of delay

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to run the table selected by mode
- mode  in  $clog2(NUM_MODES) (min 1)  table select, sampled with start
- rom_addr  out  $clog2(NUM_MODES*DEPTH)  ROM read address
- rom_data  in  2+REG_ADDR_W+REG_DATA_W  entry {op[1:0], addr, data}, valid one cycle after rom_addr
- cmd_valid  out  1  write command valid
- cmd_ready  in  1  bus master accepts command
- cmd_addr  out  REG_ADDR_W  register address
- cmd_data  out  REG_DATA_W  register value
- busy  out  1  sequence in progress
- done  out  1  sequence finished, held until next start
- error  out  1  sequence ended by overflow or reserved opcode, held until next start

## Operation
- Opcodes:
  - 2'b00 WRITE: issue {addr, data}.
  - 2'b01 DELAY: wait {addr, data} ms.
  - 2'b10 END: finish cleanly.
  - 2'b11 reserved: finish with error.
- FSM states: IDLE, FETCH, DECODE, ISSUE, DELAY, DONE.
- IDLE/DONE + start → FETCH:
  - latch base = mode*DEPTH; index = 0.
  - clear done and error; busy = 1.
  - mode ≥ NUM_MODES → DONE with error = 1, no ROM access.
- FETCH: rom_addr = base + index → DECODE.
- DECODE: register rom_data.
  - WRITE → ISSUE.
  - DELAY with value 0 → index+1, FETCH.
  - DELAY with value > 0 → load counter with value*DELAY_TICKS_PER_MS − 1, go to DELAY.
  - END → DONE.
  - reserved → DONE with error = 1.
- ISSUE: cmd_valid = 1, with cmd_addr/cmd_data stable until cmd_valid && cmd_ready. On handshake: index+1, then:
  - index was DEPTH−1 → DONE with error = 1 (table overflow, no END).
  - otherwise → FETCH.
- DELAY: count down to 0, then index+1 and apply the same overflow rule as ISSUE.
- DONE: busy = 0, done = 1. start restarts, possibly with a different mode.
- start while busy: ignored.
- Delay counter width: wide enough for (2^(REG_ADDR_W+REG_DATA_W)−1)*DELAY_TICKS_PER_MS. No truncation.

## Timing
- Reset values: rom_addr 0, cmd_valid 0, cmd_addr 0, cmd_data 0, busy 0, done 0, error 0. State IDLE.
- All outputs are registered.
- start sampled high at edge N:
  - busy = 1 and rom_addr valid from edge N+1.
  - cmd_valid = 1 from edge N+3 for a WRITE first entry.
- Per WRITE entry with cmd_ready tied high: 3 cycles (FETCH, DECODE, ISSUE).
- Handshake at edge H: cmd_valid low after H. The next command is valid no earlier than H+3.
- DELAY of D ms: exactly D*DELAY_TICKS_PER_MS cycles spent in DELAY state.
- done/error assert on the edge after the terminating DECODE, or after the terminating handshake/delay for overflow.
- rst_n assertion mid-operation: immediate return to reset values, including cmd_valid dropping without a handshake. No resume.

## Configuration
- SENSOR_SEQ_DELAY_EN defined: DELAY opcode behaves as above.
- SENSOR_SEQ_DELAY_EN undefined:
  - delay counter and DELAY state are not built.
  - DELAY entries are skipped as a no-op (DECODE → index+1 → FETCH), with no error.

## Test plan
- Mode 0 table {WRITE 12/80, WRITE 11/00, END}, cmd_ready = 1, start at edge 0 → cmd_valid at edges 3 and 6 with 0x12/0x80 then 0x11/0x00; done = 1, error = 0 at edge 8.
- cmd_ready held low 10 cycles on the first WRITE → cmd_valid, cmd_addr and cmd_data stable for all 10 cycles; exactly one transfer.
- DELAY 2 ms with DELAY_TICKS_PER_MS = 10 → exactly 20 cycles between the preceding handshake's FETCH restart and the next FETCH (+ pipeline). With the macro undefined → no stall.
- Mode 1 table of DEPTH WRITEs with no END → DEPTH commands, then done = 1, error = 1. A reserved-opcode entry → done = 1, error = 1 immediately.
- rst_n pulsed low while cmd_valid = 1 → all outputs 0 asynchronously. A later start re-runs from index 0.
- start pulsed while busy → ignored. start in DONE with mode = 1 → rom_addr begins at DEPTH.
